// File: rtl/t01_vga_rx_monitor.sv
// Receive-side VGA monitor: recovers pixel position from hsync/vsync, locks to the
// frame timing, counts timing violations and captures the colour at a requested pixel.
module t01_vga_rx_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int H_START  = 144,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int V_START  = 35
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] rgb_in,
  input  logic [9:0] cap_x,
  input  logic [9:0] cap_y,
  input  logic       cap_req,
  output logic       cap_ack,
  output logic [2:0] cap_color,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       active,
  output logic       locked,
  output logic       frame_done,
  output logic [7:0] err_count
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_BEG  = 10'(H_START);
  localparam logic [9:0] H_END  = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_BEG  = 10'(V_START);
  localparam logic [9:0] V_END  = 10'(V_START + V_ACTIVE);

  typedef enum logic [1:0] {S_SEARCH, S_ACQUIRE, S_LOCKED} sync_state_t;
  typedef enum logic [1:0] {C_IDLE, C_ARMED, C_WAIT} cap_state_t;

  logic        hs_r, vs_r, hs_d, vs_d;
  logic [2:0]  rgb_r, rgb_d;
  logic        hs_fall, vs_fall;
  logic [9:0]  h_cnt, v_cnt;
  logic        vs_seen;
  sync_state_t state, state_n;
  logic        skip_line, skip_line_n;
  logic        fault;
  cap_state_t  cap_state, cap_state_n;
  logic [9:0]  cap_xl, cap_yl;
  logic        cap_hit;

  // rgb is delayed twice so it lines up with h_cnt/v_cnt for the capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      hs_r  <= 1'b1;
      vs_r  <= 1'b1;
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      rgb_r <= '0;
      rgb_d <= '0;
    end else begin
      hs_r  <= hsync;
      vs_r  <= vsync;
      hs_d  <= hs_r;
      vs_d  <= vs_r;
      rgb_r <= rgb_in;
      rgb_d <= rgb_r;
    end
  end

  assign hs_fall = hs_d & ~hs_r;
  assign vs_fall = vs_d & ~vs_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt   <= '0;
      v_cnt   <= '0;
      vs_seen <= 1'b0;
    end else begin
      if (hs_fall)
        h_cnt <= '0;
      else if (h_cnt != '1)
        h_cnt <= h_cnt + 1'b1;
      if (hs_fall) begin
        vs_seen <= 1'b0;
        if (vs_seen || vs_fall)
          v_cnt <= '0;
        else if (v_cnt != '1)
          v_cnt <= v_cnt + 1'b1;
      end else if (vs_fall) begin
        vs_seen <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    skip_line_n = skip_line;
    fault       = 1'b0;
    unique case (state)
      S_SEARCH: begin
        if (vs_fall) begin
          state_n     = S_ACQUIRE;
          skip_line_n = 1'b1;
        end
      end
      S_ACQUIRE: begin
        if (hs_fall)
          skip_line_n = 1'b0;
        if ((hs_fall && !skip_line && h_cnt != H_LAST) || (vs_fall && v_cnt != V_LAST))
          state_n = S_SEARCH;
        else if (vs_fall)
          state_n = S_LOCKED;
      end
      S_LOCKED: begin
        fault = (hs_fall && h_cnt != H_LAST) || (vs_fall && v_cnt != V_LAST) || (h_cnt == '1);
        if (fault)
          state_n = S_SEARCH;
      end
      default: state_n = S_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_SEARCH;
      skip_line  <= 1'b0;
      frame_done <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      skip_line  <= skip_line_n;
      frame_done <= vs_fall && (state == S_LOCKED);
      if (fault && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

  assign locked = (state == S_LOCKED);

  always_comb begin
    active = locked && (h_cnt >= H_BEG) && (h_cnt < H_END) && (v_cnt >= V_BEG) && (v_cnt < V_END);
    x_out  = active ? h_cnt - H_BEG : '0;
    y_out  = active ? v_cnt - V_BEG : '0;
  end

  assign cap_hit = active && (x_out == cap_xl) && (y_out == cap_yl);

  // ARMED deliberately survives loss of lock; only dropping cap_req or reset disarms it
  always_comb begin
    cap_state_n = cap_state;
    unique case (cap_state)
      C_IDLE:  if (cap_req) cap_state_n = C_ARMED;
      C_ARMED: begin
        if (!cap_req)
          cap_state_n = C_IDLE;
        else if (cap_hit)
          cap_state_n = C_WAIT;
      end
      C_WAIT:  if (!cap_req) cap_state_n = C_IDLE;
      default: cap_state_n = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_state <= C_IDLE;
      cap_xl    <= '0;
      cap_yl    <= '0;
      cap_ack   <= 1'b0;
      cap_color <= '0;
    end else begin
      cap_state <= cap_state_n;
      cap_ack   <= (cap_state == C_ARMED) && cap_req && cap_hit;
      if ((cap_state == C_ARMED) && cap_req && cap_hit)
        cap_color <= rgb_d;
      if ((cap_state == C_IDLE) && cap_req) begin
        cap_xl <= cap_x;
        cap_yl <= cap_y;
      end
    end
  end

endmodule
